// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction source for the 9-bit simple processor.
// Holds a small program memory loaded word-by-word, issues instructions on
// Start (appending the immediate word of every mvi), waits for Done between
// instructions, and flags a Fault on Done timeout or a truncated mvi.
module instr_sequencer #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW:0]      ProgLen,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Done,
  output logic [WIDTH-1:0] DIN,
  output logic             Run,
  output logic             Busy,
  output logic             Halted,
  output logic             Fault,
  output logic [AW-1:0]    PC
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MVI = 3'b001;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [2:0]       state_q,  state_d;
  logic [WIDTH-1:0] din_q,    din_d;
  logic             run_q,    run_d;
  logic             busy_q,   busy_d;
  logic             halted_q, halted_d;
  logic             fault_q,  fault_d;
  logic [AW-1:0]    pc_q,     pc_d;
  logic [LW-1:0]    len_q,    len_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  // Address arithmetic is done one bit wider than the memory address so that
  // a program of exactly DEPTH words compares correctly against len.
  logic [LW-1:0]    pc_ext;
  logic [LW-1:0]    pc_plus1;
  logic [LW-1:0]    pc_plus2;
  logic [LW-1:0]    pc_adv;
  logic [AW-1:0]    pc_adv_w;
  logic [AW-1:0]    imm_addr;
  logic             is_mvi;
  logic             timeout_hit;

  assign pc_ext      = {1'b0, pc_q};
  assign pc_plus1    = pc_ext + LW'(1);
  assign pc_plus2    = pc_ext + LW'(2);
  // In IMM the current instruction is an mvi and occupies two words.
  assign pc_adv      = (state_q == S_IMM) ? pc_plus2 : pc_plus1;
  assign pc_adv_w    = pc_adv[AW-1:0];
  assign imm_addr    = pc_plus1[AW-1:0];
  // While in ISSUE, DIN holds the instruction word being decoded.
  assign is_mvi      = (din_q[WIDTH-1 -: 3] == OP_MVI);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Program memory write port; writes are locked out while a program runs.
  always_ff @(posedge Clock) begin
    if (WrEn && !busy_q) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  // Sequencer next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    run_d    = 1'b0;
    busy_d   = busy_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;

    if (Abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT, S_FAULT: begin
          if (Start) begin
            len_d    = ProgLen;
            pc_d     = '0;
            halted_d = 1'b0;
            fault_d  = 1'b0;
            cnt_d    = '0;
            if (ProgLen == '0) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              busy_d   = 1'b0;
            end else begin
              state_d = S_ISSUE;
              busy_d  = 1'b1;
              din_d   = mem_q[AW'(0)];
              run_d   = 1'b1;
            end
          end
        end

        S_ISSUE: begin
          cnt_d = '0;
          if (is_mvi) begin
            if (pc_plus1 < len_q) begin
              state_d = S_IMM;
              din_d   = mem_q[imm_addr];
            end else begin
              // mvi is the last word of the program: no immediate to send.
              state_d = S_FAULT;
              fault_d = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = S_WAIT;
          end
        end

        S_IMM, S_WAIT: begin
          if (Done) begin
            pc_d  = pc_adv_w;
            cnt_d = '0;
            if (pc_adv >= len_q) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              busy_d   = 1'b0;
            end else begin
              // Go straight back to ISSUE so Run follows Done by one cycle.
              state_d = S_ISSUE;
              din_d   = mem_q[pc_adv_w];
              run_d   = 1'b1;
            end
          end else if (timeout_hit) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  assign DIN    = din_q;
  assign Run    = run_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;
  assign Fault  = fault_q;
  assign PC     = pc_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction source for the 9-bit simple processor. It drives the processor's DIN and Run inputs and consumes its Done output, replacing manual switch entry.
- Holds a small program memory that is loaded word-by-word. On Start it issues the instructions in order and appends the immediate word for every mvi.
- Waits for Done between instructions. Flags a Fault on timeout or on a truncated program.

Parameters:
- WIDTH, 9: instruction/data word width; the opcode is bits [WIDTH-1:WIDTH-3].
- AW, 4: program memory address width; DEPTH = 2**AW words.
- TIMEOUT, 15: maximum cycles to wait for Done after Run before faulting.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- WrEn  in  1  program memory write strobe.
- WrAddr  in  AW  program memory write address.
- WrData  in  WIDTH  program word.
- ProgLen  in  AW+1  number of words to execute (0..DEPTH), sampled on Start.
- Start  in  1  begin execution at address 0.
- Abort  in  1  stop immediately.
- Done  in  1  processor completion pulse.
- DIN  out  WIDTH  word presented to the processor (registered).
- Run  out  1  instruction-valid pulse to the processor (registered).
- Busy  out  1  program executing.
- Halted  out  1  program completed normally.
- Fault  out  1  timeout or truncated mvi.
- PC  out  AW  address of the current or next instruction.

Behaviour:
- Reset (async, Resetn=0): DIN=0, Run=0, Busy=0, Halted=0, Fault=0, PC=0, state IDLE, timeout counter=0. Memory contents are not cleared.
- Memory: DEPTH x WIDTH register array.
  - Write on the clock edge when WrEn=1 and Busy=0. Writes while Busy are ignored.
  - Combinational read.
- States: IDLE, ISSUE, IMM, WAIT, HALT, FAULT.
- IDLE/HALT/FAULT + Start:
  - Latch ProgLen, set PC=0, clear Halted and Fault, Busy=1.
  - If ProgLen=0, go to HALT with Halted=1 and Busy=0.
  - Otherwise go to ISSUE.
- Entering ISSUE: DIN<=mem[PC], Run<=1.
- ISSUE: this is the only cycle with Run=1, so Run is exactly 1 cycle wide.
  - Opcode 001 (mvi) and PC+1 < len: go to IMM with DIN<=mem[PC+1], Run<=0.
  - Opcode 001 (mvi) and PC+1 >= len: go to FAULT, Run<=0.
  - Any other opcode: go to WAIT, Run<=0, DIN held.
  - Done in the ISSUE cycle is ignored.
- WAIT/IMM:
  - DIN is held and the timeout counter increments each cycle.
  - On Done=1, advance PC by 1 (non-mvi) or by 2 (mvi), modulo DEPTH, and reset the counter.
    - If the new PC >= len: go to HALT with Halted=1 and Busy=0.
    - Otherwise go to ISSUE next cycle. The gap between Done and the next Run is exactly 1 cycle.
  - If the counter reaches TIMEOUT without Done: go to FAULT with Fault=1 and Busy=0.
- HALT/FAULT: DIN holds its last value, Run=0, PC holds. Leave only on Start or reset.
- Abort (any state): next state IDLE, Run=0, Busy=0, counter cleared. PC, DIN, Halted and Fault hold.
- Priority: Resetn > Abort > Done/timeout > Start.
  - Start while Busy is ignored.
  - If Done arrives on the same cycle the counter reaches TIMEOUT, Done wins.
- Width rules:
  - PC+1 and PC+2 are computed in AW+1 bits for the comparison against len.
  - len = DEPTH is legal and executes the full memory.

Test Plan:
- Load mem[0]=9'o100 (mvi R0), mem[1]=9'o005, mem[2]=9'o201 (add R0,R1); ProgLen=3; Start; Done after 2 cycles each -> Run pulses 1 cycle with DIN=100; next cycle DIN=005; after Done, one cycle later Run with DIN=201; Halted=1, Busy=0, PC=3.
- ProgLen=0, Start -> Halted=1 the next cycle, Run never asserted, Busy=0.
- Program of 2 words where mem[1] is an mvi, ProgLen=2 -> first instruction completes; at ISSUE of PC=1, Run=1 for one cycle, then Fault=1 with no IMM word presented.
- Never assert Done after Run (TIMEOUT=15) -> Fault=1 exactly 15 cycles after leaving ISSUE, Busy=0; Start then restarts from PC=0 with Fault cleared.
- Assert Abort in WAIT -> Run=0, Busy=0 next cycle; WrEn now writes memory; an identical write attempted while Busy is ignored (readback unchanged).
- Drop Resetn mid-IMM, asynchronously without a clock edge -> DIN=0, Run=0, all flags 0, PC=0 immediately; memory contents preserved (rerun gives identical DIN sequence).
